// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: forms the next PC, stalls on `in` until the
// operator confirms, freezes on halt, and raises commit to gate architectural writes.
module pc_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            MUX_PC,
    input  logic                  halt,
    input  logic                  FLAG_input,
    input  logic                  input_confirm,
    input  logic [15:0]           IMD,
    input  logic [25:0]           address,
    input  logic [31:0]           data,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [31:0]           PC_plus1,
    output logic                  commit,
    output logic                  waiting,
    output logic                  halted,
    output logic [31:0]           retired
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAIT_IN = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  confirm_q;
    logic                  confirm_rise;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [31:0]           imd_ext;
    logic [31:0]           branch_sum;
    logic                  unused_bits;

    assign confirm_rise = input_confirm & ~confirm_q;
    assign pc_inc       = PC + 1'b1;
    assign PC_plus1     = 32'(pc_inc);

    // Branch target is formed at full width and truncated, which gives the modular wrap.
    assign imd_ext    = {{16{IMD[15]}}, IMD};
    assign branch_sum = 32'(pc_inc) + imd_ext;

    assign unused_bits = ^{branch_sum[31:ADDR_WIDTH], address[25:ADDR_WIDTH], data[31:ADDR_WIDTH]};

    always_comb begin
        pc_next = pc_inc;
        unique case (MUX_PC)
            2'd0:    pc_next = pc_inc;
            2'd1:    pc_next = branch_sum[ADDR_WIDTH-1:0];
            2'd2:    pc_next = address[ADDR_WIDTH-1:0];
            2'd3:    pc_next = data[ADDR_WIDTH-1:0];
            default: pc_next = pc_inc;
        endcase
    end

    // halt outranks FLAG_input; a confirm edge in RUN lets `in` complete with no wait.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (FLAG_input && !confirm_rise) begin
                    state_next = ST_WAIT_IN;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                if (!FLAG_input) begin
                    state_next = ST_RUN;
                end else if (confirm_rise) begin
                    commit     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            PC        <= RESET_PC;
            state     <= ST_RUN;
            waiting   <= 1'b0;
            halted    <= 1'b0;
            retired   <= '0;
            confirm_q <= 1'b0;
        end else begin
            confirm_q <= input_confirm;
            state     <= state_next;
            waiting   <= (state_next == ST_WAIT_IN);
            halted    <= (state_next == ST_HALTED);
            if (commit) begin
                PC <= pc_next;
                if (retired != 32'hFFFF_FFFF) begin
                    retired <= retired + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a behavioural model queues expected outputs per
// cycle and an independent monitor compares them against the DUT on the falling edge.
module tb_pc_fetch_ctrl;

    localparam int AW   = 10;
    localparam int PMOD = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    MUX_PC = '0;
    logic          halt = 1'b0;
    logic          FLAG_input = 1'b0;
    logic          input_confirm = 1'b0;
    logic [15:0]   IMD = '0;
    logic [25:0]   address = '0;
    logic [31:0]   data = '0;
    logic [AW-1:0] PC;
    logic [31:0]   PC_plus1;
    logic          commit;
    logic          waiting;
    logic          halted;
    logic [31:0]   retired;

    pc_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clock(clock), .reset(reset), .MUX_PC(MUX_PC), .halt(halt),
        .FLAG_input(FLAG_input), .input_confirm(input_confirm), .IMD(IMD),
        .address(address), .data(data), .PC(PC), .PC_plus1(PC_plus1),
        .commit(commit), .waiting(waiting), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        int      pc;
        int      pc_plus1;
        bit      commit;
        bit      waiting;
        bit      halted;
        longint  retired;
    } exp_t;

    exp_t exp_q[$];

    int assertions = 0;
    int failures   = 0;

    // Model state: plain integers and flags describing the fetch stage.
    bit     model_valid = 0;
    int     m_pc = 0;
    bit     m_waiting = 0;
    bit     m_halted = 0;
    longint m_retired = 0;
    bit     m_prev_key = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input int mux, input bit hlt, input bit flag,
                                 input bit key, input int imd, input int addr, input int dat);
        exp_t e;
        bit   rise;
        bit   do_commit;
        int   target;
        @(posedge clock);
        #1;
        reset         = rst;
        MUX_PC        = mux[1:0];
        halt          = hlt;
        FLAG_input    = flag;
        input_confirm = key;
        IMD           = imd[15:0];
        address       = addr[25:0];
        data          = dat;
        if (model_valid) begin
            rise      = key && !m_prev_key;
            do_commit = 0;
            if (m_halted) begin
                do_commit = 0;
            end else if (m_waiting) begin
                do_commit = flag && rise;
            end else begin
                do_commit = !hlt && (!flag || rise);
            end
            e.pc       = m_pc;
            e.pc_plus1 = (m_pc + 1) % PMOD;
            e.commit   = do_commit;
            e.waiting  = m_waiting;
            e.halted   = m_halted;
            e.retired  = m_retired;
            exp_q.push_back(e);
            if (!rst) begin
                case (mux)
                    0: target = m_pc + 1;
                    1: target = m_pc + 1 + int'($signed(imd[15:0]));
                    2: target = addr % PMOD;
                    default: target = dat % PMOD;
                endcase
                target = ((target % PMOD) + PMOD) % PMOD;
                if (m_halted) begin
                end else if (m_waiting) begin
                    if (!flag || rise) m_waiting = 0;
                end else if (hlt) begin
                    m_halted = 1;
                end else if (flag && !rise) begin
                    m_waiting = 1;
                end
                if (do_commit) begin
                    m_pc = target;
                    if (m_retired < 64'hFFFF_FFFF) m_retired++;
                end
                m_prev_key = key;
            end
        end
        if (rst) begin
            model_valid = 1;
            m_pc        = 0;
            m_waiting   = 0;
            m_halted    = 0;
            m_retired   = 0;
            m_prev_key  = 0;
        end
    endtask

    // Monitor: every falling edge with a pending expectation is one DUT observation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("PC",       longint'(PC),       longint'(e.pc));
                checkOutput("PC_plus1", longint'(PC_plus1), longint'(e.pc_plus1));
                checkOutput("commit",   longint'(commit),   longint'(e.commit));
                checkOutput("waiting",  longint'(waiting),  longint'(e.waiting));
                checkOutput("halted",   longint'(halted),   longint'(e.halted));
                checkOutput("retired",  longint'(retired),  e.retired);
            end
        end
    end

    task automatic run(input int mux, input int addr);
        applyStimulus(0, mux, 0, 0, 0, 0, addr, 0);
    endtask

    initial begin
        bit key;
        $display("[TB] starting pc_fetch_ctrl scoreboard run");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) run(0, 0);

        run(2, 5);
        applyStimulus(0, 1, 0, 0, 0, 16'hFFFC, 0, 0);
        run(2, 1023);
        run(0, 0);
        run(2, 26'h3FF_0123);
        applyStimulus(0, 3, 0, 0, 0, 0, 0, 32'h0000_0457);
        run(2, 7);
        run(2, 9);

        repeat (6) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        run(2, 12);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, int'($urandom_range(0, 3)), 0, i % 2, i % 3 == 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        run(0, 0);

        repeat (3) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        run(0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        key = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) key = ~key;
            applyStimulus($urandom_range(0, 79) == 0,
                          int'($urandom_range(0, 3)),
                          $urandom_range(0, 47) == 0,
                          $urandom_range(0, 3) == 0,
                          key,
                          int'($urandom_range(0, 65535)),
                          int'($urandom & 32'h03FF_FFFF),
                          int'($urandom));
        end

        @(negedge clock);
        #1;
        checkOutput("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
